// File: rtl/mem_access_unit.sv
// Memory-access stage: turns EX load/store requests into a single-outstanding req/ready + response bus access.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned accesses complete with an error and never reach the bus).
module mem_access_unit #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned AXI_DATA_BITS  = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ex_valid_i,
  input  logic                       ex_ren_i,
  input  logic                       ex_wen_i,
  input  logic [2:0]                 ex_funct3_i,
  input  logic [XLEN-1:0]            ex_addr_i,
  input  logic [XLEN-1:0]            ex_wdata_i,
  output logic                       mem_stall_o,
  output logic                       wb_valid_o,
  output logic [XLEN-1:0]            wb_rdata_o,
  output logic                       err_o,
  output logic                       bus_req_o,
  output logic                       bus_we_o,
  output logic [XLEN-1:0]            bus_addr_o,
  output logic [AXI_DATA_BITS/8-1:0] bus_wstrb_o,
  output logic [AXI_DATA_BITS-1:0]   bus_wdata_o,
  input  logic                       bus_ready_i,
  input  logic                       bus_rvalid_i,
  input  logic [AXI_DATA_BITS-1:0]   bus_rdata_i,
  input  logic                       bus_err_i
);

  localparam int unsigned STRB_W = AXI_DATA_BITS / 8;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          funct3_q;
  logic [1:0]          off_q;
  logic                accept_c;
  logic                timeout_c;
  logic                err_d;
  logic [XLEN-1:0]     rdata_d;
  logic [STRB_W-1:0]   strb_c;
  logic [AXI_DATA_BITS-1:0] wdata_c;

  // Lane select plus sign/zero extension of returned load data.
  function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [XLEN-1:0] data);
    logic [7:0]  b;
    logic [15:0] h;
    b = data[{off, 3'b000} +: 8];
    h = data[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  load_ext = {{(XLEN-8){b[7]}}, b};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, b};
      3'b001:  load_ext = {{(XLEN-16){h[15]}}, h};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, h};
      default: load_ext = data;
    endcase
  endfunction

  assign accept_c  = ex_valid_i && (ex_ren_i || ex_wen_i);
  assign timeout_c = (cnt_q == CNT_LAST);

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_c;
  assign misalign_c = ((ex_funct3_i[1:0] == 2'b01) && ex_addr_i[0]) ||
                      ((ex_funct3_i[1:0] == 2'b10) && (ex_addr_i[1:0] != 2'b00));
`endif

  // Store strobe generation and lane replication of store data.
  always_comb begin
    strb_c  = '0;
    wdata_c = AXI_DATA_BITS'(ex_wdata_i);
    if (ex_wen_i) begin
      case (ex_funct3_i)
        3'b000: begin
          strb_c  = STRB_W'(1) << ex_addr_i[1:0];
          wdata_c = {STRB_W{ex_wdata_i[7:0]}};
        end
        3'b001: begin
          strb_c  = STRB_W'(3) << {ex_addr_i[1], 1'b0};
          wdata_c = {(STRB_W/2){ex_wdata_i[15:0]}};
        end
        3'b010:  strb_c = '1;
        default: strb_c = '0;
      endcase
    end
  end

  // Next-state, timeout counter and completion values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = 1'b0;
    rdata_d     = '0;
    mem_stall_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          mem_stall_o = 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
          if (misalign_c) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = REQ;
            cnt_d   = '0;
          end
`else
          state_d = REQ;
          cnt_d   = '0;
`endif
        end
      end
      REQ: begin
        mem_stall_o = 1'b1;
        cnt_d       = timeout_c ? cnt_q : cnt_q + CNT_W'(1);
        if (bus_ready_i) begin
          state_d = RESP;
        end else if (timeout_c) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      RESP: begin
        mem_stall_o = 1'b1;
        cnt_d       = timeout_c ? cnt_q : cnt_q + CNT_W'(1);
        if (bus_rvalid_i) begin
          state_d = DONE;
          err_d   = bus_err_i;
          if (!bus_we_o && !bus_err_i) begin
            rdata_d = load_ext(funct3_q, off_q, XLEN'(bus_rdata_i));
          end
        end else if (timeout_c) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      funct3_q    <= '0;
      off_q       <= '0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wstrb_o <= '0;
      bus_wdata_o <= '0;
      wb_valid_o  <= 1'b0;
      err_o       <= 1'b0;
      wb_rdata_o  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bus_req_o  <= (state_d == REQ);
      wb_valid_o <= (state_d == DONE);
      err_o      <= err_d;
      wb_rdata_o <= rdata_d;
      if (state_q == IDLE && accept_c) begin
        funct3_q    <= ex_funct3_i;
        off_q       <= ex_addr_i[1:0];
        bus_we_o    <= ex_wen_i;
        bus_addr_o  <= {ex_addr_i[XLEN-1:2], 2'b00};
        bus_wstrb_o <= strb_c;
        bus_wdata_o <= wdata_c;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: lane handling, stalls, timeout, bus error and reset abort.
module tb_mem_access_unit;

  logic        clk, rst_n;
  logic        ex_valid, ex_ren, ex_wen;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic        mem_stall, wb_valid, err;
  logic [31:0] wb_rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready, bus_rvalid, bus_err;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.XLEN(32), .AXI_DATA_BITS(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid_i(ex_valid), .ex_ren_i(ex_ren), .ex_wen_i(ex_wen),
    .ex_funct3_i(ex_funct3), .ex_addr_i(ex_addr), .ex_wdata_i(ex_wdata),
    .mem_stall_o(mem_stall), .wb_valid_o(wb_valid), .wb_rdata_o(wb_rdata), .err_o(err),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr),
    .bus_wstrb_o(bus_wstrb), .bus_wdata_o(bus_wdata),
    .bus_ready_i(bus_ready), .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata),
    .bus_err_i(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Minimum-latency access: accept, ready next cycle, response the cycle after.
  logic        o_stall0, o_req, o_we, o_valid, o_err;
  logic [31:0] o_addr, o_wdata, o_rdata;
  logic [3:0]  o_strb;

  task automatic run_min(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd, input logic be);
    ex_valid = 1'b1; ex_wen = we; ex_ren = ~we; ex_funct3 = f3; ex_addr = addr; ex_wdata = wd;
    #1 o_stall0 = mem_stall;
    tick();
    ex_valid = 1'b0;
    o_req = bus_req; o_addr = bus_addr; o_strb = bus_wstrb; o_wdata = bus_wdata; o_we = bus_we;
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = rd; bus_err = be;
    tick();
    bus_rvalid = 1'b0; bus_err = 1'b0;
    o_valid = wb_valid; o_err = err; o_rdata = wb_rdata;
    tick();
  endtask

  logic        req_ok, addr_ok, stall_ok, any_valid;
  logic        v9, e9, s9;
  logic [31:0] r9;
  int          pulses;

  initial begin
    rst_n = 1'b0; ex_valid = 0; ex_ren = 0; ex_wen = 0; ex_funct3 = '0; ex_addr = '0; ex_wdata = '0;
    bus_ready = 0; bus_rvalid = 0; bus_rdata = '0; bus_err = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {28'd0, bus_req, wb_valid, err, mem_stall}, 32'h0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_rdata", wb_rdata, 32'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    rst_n = 1'b1;
    tick();

    // SB at 0x1003
    run_min(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0, 1'b0);
    chk("sb_stall0", {31'd0, o_stall0}, 32'd1);
    chk("sb_req", {31'd0, o_req}, 32'd1);
    chk("sb_we", {31'd0, o_we}, 32'd1);
    chk("sb_addr", o_addr, 32'h0000_1000);
    chk("sb_strb", {28'd0, o_strb}, 32'h8);
    chk("sb_wdata", o_wdata, 32'hA5A5_A5A5);
    chk("sb_valid", {31'd0, o_valid}, 32'd1);
    chk("sb_err", {31'd0, o_err}, 32'd0);
    chk("sb_rdata", o_rdata, 32'h0);
    chk("sb_idle", {30'd0, wb_valid, bus_req}, 32'd0);

    run_min(1'b0, 3'b000, 32'h0000_2002, 32'h0, 32'h12F4_5678, 1'b0);
    chk("lb_strb", {28'd0, o_strb}, 32'h0);
    chk("lb_rdata", o_rdata, 32'hFFFF_FFF4);
    run_min(1'b0, 3'b100, 32'h0000_2002, 32'h0, 32'h12F4_5678, 1'b0);
    chk("lbu_rdata", o_rdata, 32'h0000_00F4);
    run_min(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h12F4_5678, 1'b0);
    chk("lhu_rdata", o_rdata, 32'h0000_12F4);
    run_min(1'b0, 3'b001, 32'h0000_2000, 32'h0, 32'h12F4_8678, 1'b0);
    chk("lh_rdata", o_rdata, 32'hFFFF_8678);

    run_min(1'b1, 3'b001, 32'h0000_1002, 32'h1234_BEEF, 32'h0, 1'b0);
    chk("sh_strb", {28'd0, o_strb}, 32'hC);
    chk("sh_wdata", o_wdata, 32'hBEEF_BEEF);
    run_min(1'b1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 1'b0);
    chk("sw_strb", {28'd0, o_strb}, 32'hF);
    chk("sw_addr", o_addr, 32'h0000_1004);
    run_min(1'b1, 3'b011, 32'h0000_1008, 32'h1, 32'h0, 1'b0);
    chk("sx_req", {31'd0, o_req}, 32'd1);
    chk("sx_strb", {28'd0, o_strb}, 32'h0);

    run_min(1'b0, 3'b010, 32'h0000_2000, 32'h0, 32'h1111_1111, 1'b1);
    chk("lwerr_err", {31'd0, o_err}, 32'd1);
    chk("lwerr_rdata", o_rdata, 32'h0);
    run_min(1'b0, 3'b010, 32'h0000_3002, 32'h0, 32'hCAFE_F00D, 1'b0);
    chk("lwmis_addr", o_addr, 32'h0000_3000);
    chk("lwmis_rdata", o_rdata, 32'hCAFE_F00D);
    chk("lwmis_err", {31'd0, o_err}, 32'd0);

    // Ready held off 5 cycles; rvalid lands on the last allowed cycle.
    ex_valid = 1; ex_ren = 1; ex_wen = 0; ex_funct3 = 3'b010; ex_addr = 32'h0000_5000;
    #1 chk("st_stall0", {31'd0, mem_stall}, 32'd1);
    tick();
    req_ok = 1; addr_ok = 1; stall_ok = 1; pulses = 0;
    v9 = 0; e9 = 1; s9 = 1; r9 = '0;
    for (int c = 1; c <= 9; c++) begin
      bus_ready = (c == 6); bus_rvalid = (c == 8); bus_rdata = 32'h5555_AAAA;
      req_ok  &= (bus_req == (c <= 6));
      addr_ok &= (bus_addr == 32'h0000_5000);
      if (c <= 8) stall_ok &= mem_stall;
      if (wb_valid) pulses++;
      if (c == 9) begin v9 = wb_valid; e9 = err; r9 = wb_rdata; s9 = mem_stall; end
      tick();
    end
    bus_ready = 0; bus_rvalid = 0;
    chk("st_req", {31'd0, req_ok}, 32'd1);
    chk("st_addr", {31'd0, addr_ok}, 32'd1);
    chk("st_stall", {31'd0, stall_ok}, 32'd1);
    chk("st_done", {29'd0, v9, e9, s9}, 32'b100);
    chk("st_rdata", r9, 32'h5555_AAAA);
    chk("st_noreacc", {31'd0, bus_req}, 32'd0);
    if (wb_valid) pulses++;
    ex_valid = 0;
    tick();
    chk("st_idle", {30'd0, bus_req, wb_valid}, 32'd0);
    chk("st_pulses", 32'(pulses), 32'd1);

    // Timeout: no ready ever.
    ex_valid = 1; ex_ren = 1; ex_wen = 0; ex_funct3 = 3'b010; ex_addr = 32'h0000_4000;
    tick();
    ex_valid = 0;
    req_ok = 1; any_valid = 0;
    for (int c = 1; c <= 8; c++) begin
      req_ok &= bus_req;
      any_valid |= wb_valid;
      tick();
    end
    chk("to_req", {31'd0, req_ok}, 32'd1);
    chk("to_early", {31'd0, any_valid}, 32'd0);
    chk("to_done", {29'd0, wb_valid, err, bus_req}, 32'b110);
    chk("to_rdata", wb_rdata, 32'h0);
    tick();
    bus_rvalid = 1; bus_rdata = 32'hFFFF_FFFF;
    tick();
    bus_rvalid = 0;
    chk("to_late", {30'd0, wb_valid, bus_req}, 32'd0);
    run_min(1'b0, 3'b010, 32'h0000_4000, 32'h0, 32'h0BAD_F00D, 1'b0);
    chk("to_next", {30'd0, o_valid, o_err}, 32'b10);
    chk("to_next_rd", o_rdata, 32'h0BAD_F00D);

    // Asynchronous reset while waiting for the response.
    ex_valid = 1; ex_ren = 1; ex_wen = 0; ex_funct3 = 3'b010; ex_addr = 32'h0000_6000;
    tick();
    ex_valid = 0; bus_ready = 1;
    tick();
    bus_ready = 0;
    chk("rr_resp", {30'd0, mem_stall, bus_req}, 32'b10);
    rst_n = 0;
    #1;
    chk("rr_abort", {29'd0, mem_stall, bus_req, wb_valid}, 32'd0);
    bus_rvalid = 1; bus_rdata = 32'h1234_5678;
    #2 rst_n = 1;
    tick();
    bus_rvalid = 0;
    chk("rr_nowb1", {31'd0, wb_valid}, 32'd0);
    tick();
    chk("rr_nowb2", {30'd0, wb_valid, bus_req}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
